conv_frame_sequencer: RTL and testbench

Frame-level controller for the 3x3 grey-scale convolution datapath. It sits between the camera pixel source and the convolution wrapper. It accepts exactly one frame of pixels per start request and latches the kernel selection at the frame boundary. After the last real pixel it injects zero-valued flush pixels so the line-buffered window drains, then counts datapath outputs and signals frame completion.

---
 rtl/conv_seq_pkg.sv | 10 +
 rtl/conv_frame_sequencer_if.sv | 33 +++
 rtl/conv_seq_pos_counter.sv | 31 +++
 rtl/conv_frame_sequencer.sv | 114 +++++++++++
 tb/tb_conv_frame_sequencer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state and kernel encodings for the frame sequencer
package conv_seq_pkg;
    typedef enum logic [2:0] {IDLE, ACTIVE, FLUSH, DRAIN, DONE} conv_seq_state_t;
    typedef enum logic [1:0] {
        KERNEL_SOBEL_X = 2'd0,
        KERNEL_SOBEL_Y = 2'd1,
        KERNEL_PASS    = 2'd2,
        KERNEL_BLUR    = 2'd3
    } conv_kernel_t;
endpackage

// File: rtl/conv_frame_sequencer_if.sv
// conv_frame_sequencer_if: pixel source, datapath and status signals of the frame sequencer
interface conv_frame_sequencer_if #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 12
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    logic              i_start;
    logic [1:0]        i_kernel_sel;
    logic              i_pix_valid;
    logic [DATA_W-1:0] i_pix;
    logic              o_pix_ready;
    logic              o_conv_valid;
    logic [DATA_W-1:0] o_conv_val;
    logic [1:0]        o_kernel_sel;
    logic              i_conv_valid;
    logic              o_busy;
    logic              o_frame_done;
    logic              o_error;
    logic [XW-1:0]     o_x;
    logic [YW-1:0]     o_y;
    modport slave (
        input  i_start, i_kernel_sel, i_pix_valid, i_pix, i_conv_valid,
        output o_pix_ready, o_conv_valid, o_conv_val, o_kernel_sel, o_busy,
               o_frame_done, o_error, o_x, o_y
    );
    modport master (
        output i_start, i_kernel_sel, i_pix_valid, i_pix, i_conv_valid,
        input  o_pix_ready, o_conv_valid, o_conv_val, o_kernel_sel, o_busy,
               o_frame_done, o_error, o_x, o_y
    );
endinterface

// File: rtl/conv_seq_pos_counter.sv
// conv_seq_pos_counter: raster x/y position of the next accepted pixel with last-pixel flag
module conv_seq_pos_counter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int XW         = $clog2(IMG_WIDTH),
    parameter int YW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);
    logic x_end;
    assign x_end = x == XW'(IMG_WIDTH - 1);
    assign last  = x_end && y == YW'(IMG_HEIGHT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            x <= x_end ? '0 : x + 1'b1;
            y <= x_end ? y + 1'b1 : y;
        end
    end
endmodule

// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: one frame per start, zero flush after the last pixel, output counting.
// Optional DRAIN watchdog with o_error when CONV_SEQ_WATCHDOG_EN is defined.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int FLUSH_PIXELS = IMG_WIDTH + 1,
    parameter int DATA_W       = 12,
    parameter int WDOG_CYCLES  = 4096
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    conv_frame_sequencer_if.slave bus
);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int OW    = $clog2(TOTAL + 1);
    localparam int FW    = $clog2(FLUSH_PIXELS + 1);

    conv_seq_state_t   state, state_nx;
    conv_kernel_t      kernel;
    logic [FW-1:0]     flush_cnt;
    logic [OW-1:0]     out_cnt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              ready, accept, start_ok, last, flush_end, cnt_full, wd_exp;
    logic              conv_valid;
    logic [DATA_W-1:0] conv_val;

    assign ready     = state == ACTIVE;
    assign accept    = ready && bus.i_pix_valid;
    assign start_ok  = state == IDLE && bus.i_start;
    assign flush_end = flush_cnt == FW'(FLUSH_PIXELS - 1);
    assign cnt_full  = out_cnt == OW'(TOTAL);

    assign bus.o_pix_ready  = ready;
    assign bus.o_busy       = state != IDLE;
    assign bus.o_frame_done = state == DONE;
    assign bus.o_conv_valid = conv_valid;
    assign bus.o_conv_val   = conv_val;
    assign bus.o_kernel_sel = kernel;
    assign bus.o_x          = x;
    assign bus.o_y          = y;

    conv_seq_pos_counter #(
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .XW(XW), .YW(YW)
    ) u_pos (
        .clk(i_clk), .rst_n(i_rst_n), .clr(start_ok), .adv(accept),
        .x(x), .y(y), .last(last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.i_start ? ACTIVE : IDLE;
            ACTIVE:  state_nx = accept && last ? FLUSH : ACTIVE;
            FLUSH:   state_nx = flush_end ? DRAIN : FLUSH;
            DRAIN:   state_nx = cnt_full || wd_exp ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Flush beats follow the last real pixel back-to-back with zero data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conv_valid <= 1'b0;
            conv_val   <= '0;
            kernel     <= KERNEL_SOBEL_X;
            flush_cnt  <= '0;
            out_cnt    <= '0;
        end else begin
            conv_valid <= accept || state == FLUSH;
            conv_val   <= accept ? bus.i_pix : '0;
            flush_cnt  <= state == FLUSH ? flush_cnt + 1'b1 : '0;
            if (start_ok)
                kernel <= conv_kernel_t'(bus.i_kernel_sel);
            if (start_ok)
                out_cnt <= '0;
            else if (state inside {ACTIVE, FLUSH, DRAIN} && bus.i_conv_valid && !cnt_full)
                out_cnt <= out_cnt + 1'b1;
        end
    end

`ifdef CONV_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          err;
    assign wd_exp      = wd_cnt == WW'(WDOG_CYCLES - 1);
    assign bus.o_error = state == DONE && err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= state == DRAIN ? wd_cnt + 1'b1 : '0;
            if (start_ok)
                err <= 1'b0;
            else if (state == DRAIN && wd_exp && !cnt_full)
                err <= 1'b1;
        end
    end
`else
    assign wd_exp      = 1'b0;
    assign bus.o_error = 1'b0;
`endif
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: randomized frames checked against a cycle-level model of the frame rules.
// Define CONV_SEQ_WATCHDOG_EN to also exercise the DRAIN watchdog.
module tb_conv_frame_sequencer;
    localparam int W = 4, H = 3, FL = 5, DW = 12, WD = 16, TOTAL = W * H, BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0, cyc = 0;

    always #5 clk = ~clk;

    conv_frame_sequencer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) bus ();

    conv_frame_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .FLUSH_PIXELS(FL), .DATA_W(DW), .WDOG_CYCLES(WD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.o_busy), 0);
        check({tag, "_ready"}, 32'(bus.o_pix_ready), 0);
        check({tag, "_cvalid"}, 32'(bus.o_conv_valid), 0);
        check({tag, "_done"}, 32'(bus.o_frame_done), 0);
        check({tag, "_error"}, 32'(bus.o_error), 0);
    endtask

    // mode: 0 = valid held high with pixels 1..N, 1 = valid alternating, 2 = random valid/pixels
    task automatic run_frame(input int kern, input int mode, input int beats,
                             input int mid_kern, input bit mid_start);
        int n = 0, sent = 0, t = -1, c = -1, done_e = -1, start_e, normal;
        bit err_exp = 0, acc, mid_done = 0, fin = 0;
        logic [DW-1:0] pix;
        bus.i_kernel_sel = 2'(kern);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        start_e = cyc;
        check("start_busy", 32'(bus.o_busy), 1);
        check("start_ready", 32'(bus.o_pix_ready), 1);
        check("start_kernel", 32'(bus.o_kernel_sel), 32'(kern));
        check("start_x", 32'(bus.o_x), 0);
        check("start_y", 32'(bus.o_y), 0);
        while (!fin) begin
            acc = 1'b0;
            bus.i_pix_valid = mode == 0 ? 1'b1 :
                              mode == 1 ? 1'((cyc - start_e) % 2 == 0) : 1'($urandom_range(1));
            pix = mode == 0 ? DW'(n + 1) : DW'($urandom);
            bus.i_pix = pix;
            if (bus.i_pix_valid && n < TOTAL) begin
                acc = 1'b1;
                n++;
                if (n == TOTAL) t = cyc + 1;
            end
            bus.i_conv_valid = sent < beats && $urandom_range(1) == 1;
            if (bus.i_conv_valid) begin
                sent++;
                if (sent == TOTAL) c = cyc + 1;
            end
            if (n == 5 && !mid_done) begin
                bus.i_kernel_sel = 2'(mid_kern);
                bus.i_start = mid_start;
                mid_done = 1'b1;
            end
            if (t >= 0) begin
                normal = c < 0 ? BIG : (c + 1 > t + FL + 1 ? c + 1 : t + FL + 1);
`ifdef CONV_SEQ_WATCHDOG_EN
                done_e  = normal < t + FL + WD ? normal : t + FL + WD;
                err_exp = t + FL + WD < normal;
`else
                done_e  = normal;
`endif
            end
            tick();
            bus.i_start = 1'b0;
            check("ready", 32'(bus.o_pix_ready), 32'(n < TOTAL));
            check("busy", 32'(bus.o_busy), 1);
            check("x", 32'(bus.o_x), 32'(n % W));
            check("y", 32'(bus.o_y), 32'(n / W));
            check("conv_valid", 32'(bus.o_conv_valid),
                  32'(acc || (t >= 0 && cyc >= t + 1 && cyc <= t + FL)));
            check("conv_val", 32'(bus.o_conv_val), acc ? 32'(pix) : 0);
            check("kernel", 32'(bus.o_kernel_sel), 32'(kern));
            check("frame_done", 32'(bus.o_frame_done), 32'(cyc == done_e));
            check("error", 32'(bus.o_error), 32'(cyc == done_e && err_exp));
            if (cyc == done_e) fin = 1'b1;
            else if (cyc - start_e > 300) begin
                check("frame_timeout", 32'(fin), 1);
                fin = 1'b1;
            end
        end
        bus.i_pix_valid  = 1'b0;
        bus.i_conv_valid = 1'b0;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check_idle_outputs("after_done");
        check("after_done_kernel", 32'(bus.o_kernel_sel), 32'(kern));
    endtask

    initial begin
        bus.i_start      = 1'b1;
        bus.i_kernel_sel = 2'd3;
        bus.i_pix_valid  = 1'b1;
        bus.i_pix        = '1;
        bus.i_conv_valid = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_val", 32'(bus.o_conv_val), 0);
        check("reset_kernel", 32'(bus.o_kernel_sel), 0);
        check("reset_x", 32'(bus.o_x), 0);
        check("reset_y", 32'(bus.o_y), 0);
        bus.i_start      = 1'b0;
        bus.i_pix_valid  = 1'b0;
        bus.i_conv_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");

        run_frame(2, 0, TOTAL, 2, 1'b0);
        run_frame(0, 1, TOTAL, 0, 1'b0);
        run_frame(1, 2, TOTAL, 3, 1'b1);
        run_frame(3, 2, TOTAL + 3, 3, 1'b0);
        run_frame(2, 0, TOTAL, 2, 1'b0);
`ifdef CONV_SEQ_WATCHDOG_EN
        run_frame(0, 0, 10, 0, 1'b0);
        run_frame(1, 2, TOTAL, 1, 1'b0);
`endif

        // Reset asserted while flush beats are going out aborts the frame
        bus.i_kernel_sel = 2'd1;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_pix_valid = 1'b1;
        repeat (TOTAL) tick();
        bus.i_pix_valid = 1'b0;
        repeat (2) tick();
        check("flush_cvalid", 32'(bus.o_conv_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) begin
            tick();
            check("abort_done", 32'(bus.o_frame_done), 0);
            check("abort_busy", 32'(bus.o_busy), 0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            run_frame(int'($urandom_range(3)), int'($urandom_range(2)), TOTAL + int'($urandom_range(3)),
                      int'($urandom_range(3)), 1'($urandom_range(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
